vregfile_seq: RTL and testbench

Sequencer around the single-port vector register file: accepts one vector operation at a time, reads 0–3 source operands from an internal single-port RAM into operand registers, presents them to the vector execution unit, waits for its result, writes the result back, and signals completion. Sits between the vector decode/issue stage and the vector ALU. It generalises the fixed three-read VRF wrapper with a runtime operand count, a ready/valid request handshake, an unbounded execution wait and a conditional write-back.

---
 rtl/vregfile_seq.sv | 184 ++++++++++++++++++
 tb/tb_vregfile_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vregfile_seq.sv
// Vector register file sequencer: reads 0..3 operands from a single-port RAM,
// waits for the execution result and conditionally writes it back.
// Optional completed-operation counter enabled by defining VREGFILE_SEQ_OPCNT_EN.

module ram_1p #(
  parameter int unsigned DataWidth = 128,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 i_clk,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [AddrWidth-1:0] i_addr,
  input  logic [DataWidth-1:0] i_wdata,
  output logic [DataWidth-1:0] o_rdata
);
  logic [DataWidth-1:0] r_mem [0:(2**AddrWidth)-1];
  logic [DataWidth-1:0] r_rdata;

  // read data holds its value until the next read request
  always_ff @(posedge i_clk) begin
    if (i_req) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

module vregfile_seq #(
  parameter int unsigned DataWidth = 128,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 ready_o,
  input  logic [1:0]           num_operands_i,
  input  logic [AddrWidth-1:0] raddr_a_i,
  input  logic [AddrWidth-1:0] raddr_b_i,
  input  logic [AddrWidth-1:0] raddr_c_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic [DataWidth-1:0] rdata_c_o,
  output logic                 operands_valid_o,
  input  logic                 result_valid_i,
  input  logic [DataWidth-1:0] result_i,
  output logic                 vector_done_o,
  output logic [31:0]          op_count_o
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_EXEC, S_WRITE} state_e;

  state_e               r_state, w_state_next;
  logic [1:0]           r_num, r_idx;
  logic [AddrWidth-1:0] r_raddr_a, r_raddr_b, r_raddr_c, r_waddr;
  logic                 r_we;
  logic [DataWidth-1:0] r_op_a, r_op_b, r_op_c, r_result;

  logic                 w_ram_req, w_ram_we;
  logic [AddrWidth-1:0] w_ram_addr;
  logic [DataWidth-1:0] w_ram_rdata;

  ram_1p #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) u_ram (
    .i_clk   (clk_i),
    .i_req   (w_ram_req),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_result),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    ready_o          = 1'b0;
    operands_valid_o = 1'b0;
    vector_done_o    = 1'b0;
    w_ram_req        = 1'b0;
    w_ram_we         = 1'b0;
    w_ram_addr       = r_raddr_a;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (req_i) w_state_next = (num_operands_i == 2'd0) ? S_EXEC : S_READ;
      end
      S_READ: begin
        w_ram_req = 1'b1;
        case (r_idx)
          2'd1:    w_ram_addr = r_raddr_b;
          2'd2:    w_ram_addr = r_raddr_c;
          default: w_ram_addr = r_raddr_a;
        endcase
        if (r_idx == r_num - 2'd1) w_state_next = S_CAPTURE;
      end
      S_CAPTURE: w_state_next = S_EXEC;
      S_EXEC: begin
        operands_valid_o = 1'b1;
        if (result_valid_i) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        vector_done_o = 1'b1;
        w_ram_req     = r_we;
        w_ram_we      = r_we;
        w_ram_addr    = r_waddr;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture trails the read request by one cycle: READ fills idx-1,
  // CAPTURE fills the final operand.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_num     <= '0;
      r_idx     <= '0;
      r_raddr_a <= '0;
      r_raddr_b <= '0;
      r_raddr_c <= '0;
      r_waddr   <= '0;
      r_we      <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_c    <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_num     <= num_operands_i;
            r_idx     <= '0;
            r_raddr_a <= raddr_a_i;
            r_raddr_b <= raddr_b_i;
            r_raddr_c <= raddr_c_i;
            r_we      <= we_i;
            r_waddr   <= waddr_i;
            if (num_operands_i < 2'd1) r_op_a <= '0;
            if (num_operands_i < 2'd2) r_op_b <= '0;
            if (num_operands_i < 2'd3) r_op_c <= '0;
          end
        end
        S_READ: begin
          if (r_idx == 2'd1) r_op_a <= w_ram_rdata;
          if (r_idx == 2'd2) r_op_b <= w_ram_rdata;
          r_idx <= r_idx + 2'd1;
        end
        S_CAPTURE: begin
          case (r_num)
            2'd1:    r_op_a <= w_ram_rdata;
            2'd2:    r_op_b <= w_ram_rdata;
            default: r_op_c <= w_ram_rdata;
          endcase
        end
        S_EXEC: begin
          if (result_valid_i) r_result <= result_i;
        end
        default: ;
      endcase
    end
  end

  assign rdata_a_o = r_op_a;
  assign rdata_b_o = r_op_b;
  assign rdata_c_o = r_op_c;

`ifdef VREGFILE_SEQ_OPCNT_EN
  logic [31:0] r_op_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                r_op_count <= '0;
    else if (r_state == S_WRITE) r_op_count <= r_op_count + 32'd1;
  end

  assign op_count_o = r_op_count;
`else
  assign op_count_o = '0;
`endif
endmodule

// File: tb/tb_vregfile_seq.sv
// Directed self-checking bench for vregfile_seq with an operand scoreboard
// and a reference model of register contents.

module tb_vregfile_seq;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i;
  logic          ready_o;
  logic [1:0]    num_operands_i;
  logic [AW-1:0] raddr_a_i, raddr_b_i, raddr_c_i, waddr_i;
  logic          we_i;
  logic [DW-1:0] rdata_a_o, rdata_b_o, rdata_c_o, result_i;
  logic          operands_valid_o, result_valid_i, vector_done_o;
  logic [31:0]   op_count_o;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mdl [0:31];
  int            errors = 0;
  int            checks = 0;

  always #5 clk_i = ~clk_i;

  vregfile_seq #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_i            (req_i),
    .ready_o          (ready_o),
    .num_operands_i   (num_operands_i),
    .raddr_a_i        (raddr_a_i),
    .raddr_b_i        (raddr_b_i),
    .raddr_c_i        (raddr_c_i),
    .we_i             (we_i),
    .waddr_i          (waddr_i),
    .rdata_a_o        (rdata_a_o),
    .rdata_b_o        (rdata_b_o),
    .rdata_c_o        (rdata_c_o),
    .operands_valid_o (operands_valid_o),
    .result_valid_i   (result_valid_i),
    .result_i         (result_i),
    .vector_done_o    (vector_done_o),
    .op_count_o       (op_count_o)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge where the DUT must be idle; returns at the
  // falling edge where it must be idle again.
  task automatic do_op(input int n, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] c, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] res, input int delay, input bit hold_req);
    exp_t e;
    int   k;
    chk("ready_t0", ready_o, 1);
    e.a = (n >= 1) ? mdl[a] : '0;
    e.b = (n >= 2) ? mdl[b] : '0;
    e.c = (n >= 3) ? mdl[c] : '0;
    sb.push_back(e);
    req_i = 1'b1; num_operands_i = n[1:0];
    raddr_a_i = a; raddr_b_i = b; raddr_c_i = c; we_i = we; waddr_i = wa;
    @(negedge clk_i);
    if (!hold_req) req_i = 1'b0;
    num_operands_i = ~n[1:0];
    raddr_a_i = ~a; raddr_b_i = ~b; raddr_c_i = ~c; we_i = ~we; waddr_i = ~wa;
    k = 1;
    while (operands_valid_o !== 1'b1 && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    chk("exec_latency", DW'(k), DW'((n == 0) ? 1 : n + 2));
    e = sb.pop_front();
    chk("rdata_a", rdata_a_o, e.a);
    chk("rdata_b", rdata_b_o, e.b);
    chk("rdata_c", rdata_c_o, e.c);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      chk("wait_valid", operands_valid_o, 1);
      chk("wait_ready", ready_o, 0);
      chk("wait_done", vector_done_o, 0);
    end
    result_valid_i = 1'b1; result_i = res;
    @(negedge clk_i);
    req_i = 1'b0; result_valid_i = 1'b0; result_i = ~res;
    chk("done_pulse", vector_done_o, 1);
    chk("valid_drop", operands_valid_o, 0);
    if (we) mdl[wa] = res;
    @(negedge clk_i);
    chk("done_once", vector_done_o, 0);
    chk("hold_a", rdata_a_o, e.a);
    chk("hold_c", rdata_c_o, e.c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_cnt;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    rst_ni = 1'b0; req_i = 1'b0; num_operands_i = '0; raddr_a_i = '0; raddr_b_i = '0;
    raddr_c_i = '0; we_i = 1'b0; waddr_i = '0; result_valid_i = 1'b0; result_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", operands_valid_o, 0);
    chk("rst_done", vector_done_o, 0);
    chk("rst_rdata_a", rdata_a_o, '0);
    chk("rst_opcnt", op_count_o, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    do_op(0, 0, 0, 0, 1'b1, 5'd3, {16{8'hA5}}, 0, 1'b0);
    do_op(1, 5'd3, 0, 0, 1'b0, 5'd0, '0, 0, 1'b0);
    do_op(0, 0, 0, 0, 1'b1, 5'd1, {16{8'h11}}, 0, 1'b0);
    do_op(0, 0, 0, 0, 1'b1, 5'd2, {16{8'h22}}, 0, 1'b0);
    do_op(0, 0, 0, 0, 1'b1, 5'd3, {16{8'h33}}, 0, 1'b0);
    do_op(3, 5'd1, 5'd2, 5'd3, 1'b0, 5'd1, '1, 0, 1'b0);
    do_op(1, 5'd2, 0, 0, 1'b0, 5'd2, '1, 0, 1'b0);
    do_op(2, 5'd1, 5'd3, 0, 1'b0, 5'd1, {8{16'hDEAD}}, 10, 1'b1);
    do_op(1, 5'd1, 0, 0, 1'b0, 5'd0, '0, 0, 1'b0);
    do_op(0, 0, 0, 0, 1'b1, 5'd5, {16{8'h55}}, 0, 1'b0);
    do_op(3, 5'd5, 5'd3, 5'd2, 1'b0, 5'd0, '0, 2, 1'b0);

    req_i = 1'b1; num_operands_i = 2'd2; raddr_a_i = 5'd1; raddr_b_i = 5'd2;
    we_i = 1'b1; waddr_i = 5'd1;
    @(negedge clk_i);
    req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_valid", operands_valid_o, 0);
    chk("midrst_done", vector_done_o, 0);
    chk("midrst_rdata_a", rdata_a_o, '0);
    chk("midrst_rdata_b", rdata_b_o, '0);
    chk("midrst_rdata_c", rdata_c_o, '0);
    chk("midrst_opcnt", op_count_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    do_op(2, 5'd1, 5'd2, 0, 1'b0, 5'd0, '0, 0, 1'b0);
    do_op(3, 5'd3, 5'd1, 5'd5, 1'b1, 5'd6, {4{32'h0BADF00D}}, 1, 1'b0);
    do_op(1, 5'd6, 0, 0, 1'b0, 5'd0, '0, 0, 1'b0);
    do_op(0, 0, 0, 0, 1'b0, 5'd1, '1, 0, 1'b0);
`ifdef VREGFILE_SEQ_OPCNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    chk("op_count", op_count_o, exp_cnt);
    do_op(1, 5'd1, 0, 0, 1'b0, 5'd0, '0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
